decrypt_pipe_unshift: RTL and testbench

Decrypt-side counterpart of the encrypt shift/scramble stage. It receives cipher characters and undoes the alphabetic rotation: each letter is rotated back by the current shift amount modulo 26, and the letter's case is preserved. Non-letters pass through unchanged. The block holds its own shift schedule, which advances every `rot_freq` letters, so it stays aligned with the encrypt side. It is a 2-stage valid/ready pipeline that sits between the XOR-undo stage and the decrypted-data sink.

---
 rtl/decrypt_pipe_unshift.sv | 137 +++++++++++++
 tb/tb_decrypt_pipe_unshift.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_pipe_unshift.sv
// decrypt_pipe_unshift: two-stage valid/ready pipeline that rotates cipher
// letters back by a scheduled shift amount. Letter case is preserved, and
// non-letters and bypassed characters pass through unchanged.
module decrypt_pipe_unshift (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       in_ready,
  input  logic [7:0] din,
  input  logic       mode,
  input  logic       shift_en,
  input  logic [2:0] shift_amt,
  input  logic [2:0] rot_freq,
  input  logic       cfg_load,
  output logic       en_out,
  input  logic       out_ready,
  output logic [7:0] data_out
);

  // Shift schedule
  logic [2:0] cur_shift_q, cur_shift_d;
  logic [2:0] char_cnt_q,  char_cnt_d;

  // Stage 1: captured character, its shift, and whether it gets rotated
  logic       s1_valid_q,  s1_valid_d;
  logic [7:0] s1_char_q,   s1_char_d;
  logic [2:0] s1_shift_q,  s1_shift_d;
  logic       s1_active_q, s1_active_d;

  // Stage 2: output register
  logic       en_out_q,    en_out_d;
  logic [7:0] data_out_q,  data_out_d;

  logic       s1_adv;
  logic       s2_adv;
  logic       accept;
  logic       in_letter;
  logic       in_active;
  logic [4:0] idx;
  logic [4:0] out_idx;
  logic [7:0] rotated;

  // Handshake and input classification
  always_comb begin
    s2_adv    = !en_out_q || out_ready;
    s1_adv    = !s1_valid_q || s2_adv;
    in_ready  = s1_adv && !rst;
    accept    = en && in_ready;
    in_letter = ((din >= 8'd65) && (din <= 8'd90)) ||
                ((din >= 8'd97) && (din <= 8'd122));
    in_active = mode && shift_en && in_letter;
  end

  // Shift schedule update; cfg_load wins over the letter-driven increment
  always_comb begin
    cur_shift_d = cur_shift_q;
    char_cnt_d  = char_cnt_q;
    if (cfg_load) begin
      cur_shift_d = shift_amt;
      char_cnt_d  = '0;
    end else if (accept && in_active && (rot_freq != 3'd0)) begin
      if (char_cnt_q == (rot_freq - 3'd1)) begin
        char_cnt_d  = '0;
        cur_shift_d = cur_shift_q + 3'd1;
      end else begin
        char_cnt_d  = char_cnt_q + 3'd1;
      end
    end
  end

  // Stage 1 capture; the shift recorded is the value before this character's update
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_char_d   = s1_char_q;
    s1_shift_d  = s1_shift_q;
    s1_active_d = s1_active_q;
    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_char_d   = din;
        s1_shift_d  = cur_shift_q;
        s1_active_d = in_active;
      end
    end
  end

  // Rotation: 'A' (65) and 'a' (97) both have low five bits 5'd1, so the
  // letter index is char[4:0]-1 and the case lives untouched in char[7:5].
  always_comb begin
    idx = s1_char_q[4:0] - 5'd1;
    if (idx >= {2'b00, s1_shift_q}) begin
      out_idx = idx - {2'b00, s1_shift_q};
    end else begin
      out_idx = idx + 5'd26 - {2'b00, s1_shift_q};
    end
    rotated = {s1_char_q[7:5], out_idx + 5'd1};
  end

  // Stage 2 load; holds while downstream stalls
  always_comb begin
    en_out_d   = en_out_q;
    data_out_d = data_out_q;
    if (s2_adv) begin
      en_out_d = s1_valid_q;
      if (s1_valid_q) begin
        data_out_d = s1_active_q ? rotated : s1_char_q;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_shift_q <= '0;
      char_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_char_q   <= '0;
      s1_shift_q  <= '0;
      s1_active_q <= 1'b0;
      en_out_q    <= 1'b0;
      data_out_q  <= '0;
    end else begin
      cur_shift_q <= cur_shift_d;
      char_cnt_q  <= char_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_char_q   <= s1_char_d;
      s1_shift_q  <= s1_shift_d;
      s1_active_q <= s1_active_d;
      en_out_q    <= en_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign en_out   = en_out_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_decrypt_pipe_unshift.sv
// Scoreboard bench for decrypt_pipe_unshift: the driver pushes hand-computed
// expected characters on each accepted transfer; a monitor pops and compares
// whenever the DUT presents an output.
module tb_decrypt_pipe_unshift;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_ready;
  logic [7:0] din;
  logic       mode;
  logic       shift_en;
  logic [2:0] shift_amt;
  logic [2:0] rot_freq;
  logic       cfg_load;
  logic       en_out;
  logic       out_ready;
  logic [7:0] data_out;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] held;

  always #5 clk = ~clk;

  decrypt_pipe_unshift dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_ready  (in_ready),
    .din       (din),
    .mode      (mode),
    .shift_en  (shift_en),
    .shift_amt (shift_amt),
    .rot_freq  (rot_freq),
    .cfg_load  (cfg_load),
    .en_out    (en_out),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: compare every presented output against the scoreboard head
  always @(negedge clk) begin
    if (!rst && en_out && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0d required=none", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("data_out", data_out, mon_exp);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [7:0] ch, input logic m, input logic se,
                      input logic ld, input logic [2:0] amt,
                      input logic push, input logic [7:0] exp_ch);
    int n;
    en = 1'b1; din = ch; mode = m; shift_en = se; cfg_load = ld; shift_amt = amt;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accepted char=%0d", ch);
    end else if (push) begin
      exp_q.push_back(exp_ch);
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic load(input logic [2:0] amt);
    cfg_load = 1'b1;
    shift_amt = amt;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; din = '0; mode = 1'b1; shift_en = 1'b1;
    shift_amt = '0; rot_freq = '0; cfg_load = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en_out", en_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single rotation and latency
    rot_freq = 3'd0;
    load(3'd3);
    send(8'd68, 1, 1, 0, 0, 1, 8'd65);
    check("lat_early_en_out", en_out, 0);
    @(posedge clk);
    #1;
    check("lat_en_out", en_out, 1);
    check("lat_data_out", data_out, 65);
    send(8'd98, 1, 1, 0, 0, 1, 8'd121);
    drain("drain_rotation");

    // Bypass, non-letters leave the schedule untouched
    send(8'd68, 0, 1, 0, 0, 1, 8'd68);
    rot_freq = 3'd1;
    load(3'd3);
    send(8'd53, 1, 1, 0, 0, 1, 8'd53);
    send(8'd32, 1, 1, 0, 0, 1, 8'd32);
    send(8'd68, 1, 1, 0, 0, 1, 8'd65);
    send(8'd68, 1, 1, 0, 0, 1, 8'd90);
    drain("drain_bypass");

    // Schedule advance: "BB!BB"
    rot_freq = 3'd2;
    load(3'd1);
    send(8'd66, 1, 1, 0, 0, 1, 8'd65);
    send(8'd66, 1, 1, 0, 0, 1, 8'd65);
    send(8'd33, 1, 1, 0, 0, 1, 8'd33);
    send(8'd66, 1, 1, 0, 0, 1, 8'd90);
    send(8'd66, 1, 1, 0, 0, 1, 8'd90);
    drain("drain_schedule");

    // Shift wrap 7->0, then cfg_load coincident with a character
    rot_freq = 3'd1;
    load(3'd7);
    send(8'd72, 1, 1, 0, 0, 1, 8'd65);
    send(8'd72, 1, 1, 0, 0, 1, 8'd72);
    send(8'd72, 1, 1, 1, 3'd2, 1, 8'd71);
    send(8'd72, 1, 1, 0, 0, 1, 8'd70);
    drain("drain_wrap_load");

    // Backpressure: 10 back-to-back characters, out_ready low for 4 cycles
    rot_freq = 3'd0;
    load(3'd2);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [7:0] c;
          c = 8'd67 + 8'(i);
          send(c, 1, 1, 0, 0, 1, c - 8'd2);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = data_out;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("stall_data_hold", data_out, held);
          check("stall_en_out", en_out, 1);
          check("stall_in_ready", in_ready, 0);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        #1;
        check("ready_return", in_ready, 1);
      end
    join
    drain("drain_backpressure");

    // Reset mid-stream with both stages full
    rot_freq = 3'd0;
    load(3'd5);
    out_ready = 1'b0;
    send(8'd77, 1, 1, 0, 0, 0, 8'd0);
    send(8'd78, 1, 1, 0, 0, 0, 8'd0);
    check("full_en_out", en_out, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_en_out", en_out, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_in_ready_back", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(8'd68, 1, 1, 0, 0, 1, 8'd68);
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
